// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one asynchronous ROM read port among NREQ requesters.
// Latency: grant is combinational; the tagged response is registered, one cycle after accept.
// Backpressure: a one-hot req_ready grant per cycle; responses cannot be stalled.
module rom_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    output logic [NREQ-1:0]       req_ready,
    output logic [ADDRW-1:0]      rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id
);

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic [IDW:0]   scan;

    // Scan from ptr with modulo-NREQ wrap; first pending requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = (IDW+1)'(ptr) + (IDW+1)'(k);
            if (scan >= (IDW+1)'(NREQ)) begin
                scan = scan - (IDW+1)'(NREQ);
            end
            if (!gnt_any && req_valid[scan[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = scan[IDW-1:0];
            end
        end
        // Reset must silence the shared port immediately, not at the next edge.
        gnt_any = gnt_any & rst_n;
    end

    always_comb begin
        req_ready = '0;
        rom_addr  = '0;
        if (gnt_any) begin
            req_ready[gnt_idx] = 1'b1;
            rom_addr           = req_addr[int'(gnt_idx)*ADDRW +: ADDRW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= req_ready;
            if (gnt_any) begin
                ptr      <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                rsp_data <= rom_data;
                rsp_id   <= gnt_idx;
            end
        end
    end

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one asynchronous lookup-table ROM read port among `NREQ` requesters, such as oscillators or waveform generators reading the sine LUT. It grants at most one request per cycle, drives the granted address onto the shared ROM port, and returns the ROM word one cycle later. The response is registered and tagged with the requester index. The block instantiates no memory: the ROM sits beside it and is connected through `rom_addr` / `rom_data`.

## Interface
- `NREQ`, 4: number of requesters, range 2..16.
- `WIDTH`, 8: ROM data width.
- `DEPTH`, 256: ROM depth in words.
- `ADDRW`, `$clog2(DEPTH)`: localparam, ROM address width.
- `IDW`, `$clog2(NREQ)`: localparam, requester-index width.

- `clk` in 1: the single clock; all state is on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NREQ`: request from requester i; held high with a stable address until accepted.
- `req_addr` in `NREQ*ADDRW`: address of requester i at bits `[i*ADDRW +: ADDRW]`.
- `req_ready` out `NREQ`: one-hot grant; request i is accepted on a rising edge where `req_valid[i] && req_ready[i]`.
- `rom_addr` out `ADDRW`: address to the shared ROM.
- `rom_data` in `WIDTH`: combinational ROM output for `rom_addr`.
- `rsp_valid` out `NREQ`: one-hot, one-cycle pulse marking the response for requester i.
- `rsp_data` out `WIDTH`: registered ROM word; valid only while `rsp_valid` is nonzero.
- `rsp_id` out `IDW`: index of the requester that owns the current response.

## Operation
- State:
  - round-robin pointer `ptr` (`IDW` bits), the highest-priority index;
  - response registers `rsp_valid`, `rsp_data`, `rsp_id`.
- Grant, combinational:
  - `g` is the first index i with `req_valid[i]=1`, scanning `ptr`, `ptr+1`, … with modulo-`NREQ` wrap.
  - `req_ready = 1<<g` if any request is pending, else 0.
  - `rom_addr = req_addr[g]` if any request is pending, else 0.
- Pointer update:
  - On a grant, `ptr <= (g+1) mod NREQ`. For `g=NREQ-1` this wraps to 0.
  - With no request, `ptr` holds.
- Response register, every cycle:
  - `rsp_valid <= req_ready` (only the pulse is set; there is no accumulation).
  - On a grant: `rsp_data <= rom_data` and `rsp_id <= g`.
  - With no grant: `rsp_data` and `rsp_id` hold their last values.
- There is no response backpressure. Every requester must accept its response in the cycle it is presented.
- Fairness: a requester holding `req_valid` continuously is granted within `NREQ` cycles.
- Reset (`rst_n=0`), applied asynchronously:
  - `ptr=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`;
  - `req_ready` forced to 0;
  - `rom_addr` forced to 0.
- Reset mid-operation:
  - Any grant coincident with or preceding reset assertion that has not yet produced a `rsp_valid` pulse is discarded.
  - The requester must reissue after `rst_n` rises.
  - After release, arbitration restarts from index 0 on the first rising edge.

## Timing
- Cycle t: `req_valid[i]=1`, no other request pending → `req_ready[i]=1` and `rom_addr=req_addr[i]` within cycle t (zero cycles).
- Edge ending t: accept.
- Cycle t+1: `rsp_valid[i]=1`, `rsp_data=ROM[req_addr[i]]`, `rsp_id=i`.
- Latency from accept to response is exactly 1 cycle.
- Throughput is one access per cycle across all requesters combined.
- A requester may hold `req_valid` high after acceptance to issue back-to-back reads, and may change `req_addr` in the cycle after acceptance.
- Only valid→ready combinational paths exist: `req_valid`/`req_addr` → `req_ready`/`rom_addr`, plus the `rom_data` setup to the response register. There is no ready→valid dependency.

## Test plan
The bench ROM model is filled with `ROM[a] = a ^ 8'h5A`. Defaults are `NREQ=4`, `WIDTH=8`, `DEPTH=256`.
- **Reset values:** drive `rst_n=0` mid-cycle with all requests high → `req_ready=0`, `rom_addr=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_id=0` immediately, without waiting for an edge.
- **Single requester:** `req_valid=4'b0100`, `req_addr[2]=8'h10` for one cycle → `req_ready=4'b0100` that cycle; next cycle `rsp_valid=4'b0100`, `rsp_data=8'h4A`, `rsp_id=2`; the following cycle `rsp_valid=0`.
- **Full contention:** all four requesters held high, addresses 0..3 → grant order 0,1,2,3,0 on consecutive cycles; `rsp_id` follows one cycle later; `rsp_data` = `5A`, `5B`, `58`, `59`, `5A`.
- **Wrap-around:**
  - Sequence: grant 3 alone (`ptr` wraps to 0), then `req_valid=4'b1001`.
  - Required: 0 is granted before 3, and the pointer value is checked as 1.
- **Idle hold:**
  - Sequence: after a grant to 1 with response `8'h5B`, no requests for 5 cycles.
  - Required: `rsp_valid=0`, `rsp_data` holds `8'h5B`, `rsp_id` holds 1, `rom_addr=0`.
- **Reset mid-flight:**
  - Sequence: assert `rst_n=0` in the same cycle as a grant to 2, then release.
  - Required: no `rsp_valid` pulse; first post-reset grant with `4'b1111` pending goes to 0.
